// File: rtl/split.sv
// Fan-out of one multi-lane beat onto COUNT independent valid/ready streams.
// Each lane has an output register plus a one-entry skid buffer.
module split #(
  parameter int WIDTH = 32,
  parameter int COUNT = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [COUNT-1:0][WIDTH-1:0]  s_data,
  output logic [COUNT-1:0]             m_valid,
  input  logic [COUNT-1:0]             m_ready,
  output logic [COUNT-1:0][WIDTH-1:0]  m_data
);

  logic                        fire;
  logic [COUNT-1:0]            out_free;
  logic [COUNT-1:0]            out_take;
  logic [COUNT-1:0]            skid_valid;
  logic [COUNT-1:0][WIDTH-1:0] skid_data;

  logic                        s_ready_d;
  logic [COUNT-1:0]            m_valid_d;
  logic [COUNT-1:0][WIDTH-1:0] m_data_d;
  logic [COUNT-1:0]            skid_valid_d;
  logic [COUNT-1:0][WIDTH-1:0] skid_data_d;

  always_comb begin
    fire         = s_valid & s_ready;
    out_free     = ~m_valid | m_ready;
    out_take     = m_valid & m_ready;
    m_valid_d    = m_valid;
    m_data_d     = m_data;
    skid_valid_d = skid_valid;
    skid_data_d  = skid_data;
    for (int n = 0; n < COUNT; n++) begin
      unique case (1'b1)
        fire & out_free[n]: begin
          m_data_d[n]  = s_data[n];
          m_valid_d[n] = 1'b1;
        end
        fire & ~out_free[n]: begin
          skid_data_d[n]  = s_data[n];
          skid_valid_d[n] = 1'b1;
        end
        ~fire & out_free[n] & skid_valid[n]: begin
          m_data_d[n]     = skid_data[n];
          m_valid_d[n]    = 1'b1;
          skid_valid_d[n] = 1'b0;
        end
        ~fire & out_take[n] & ~skid_valid[n]: begin
          m_valid_d[n] = 1'b0;
        end
        default: ;
      endcase
    end
    // accept only when every lane can absorb one more beat
    s_ready_d = ~|skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_ready    <= 1'b1;
      m_valid    <= '0;
      skid_valid <= '0;
    end else begin
      s_ready    <= s_ready_d;
      m_valid    <= m_valid_d;
      skid_valid <= skid_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    m_data    <= m_data_d;
    skid_data <= skid_data_d;
  end

`ifdef FORMAL
  for (genvar g = 0; g < COUNT; g++) begin : g_stall
    a_stall: assert property (
      @(posedge clk) disable iff (reset)
      m_valid[g] && !m_ready[g] |=> m_valid[g] && $stable(m_data[g])
    );
  end
`endif

endmodule

// File: doc/split.md
Name: split

Overview:
- Fan-out counterpart of the stream combiner: accepts one input beat carrying COUNT lanes and delivers each lane on its own independent valid/ready output stream.
- Sits where a joined multi-lane stream must be handed to COUNT consumers that may stall independently.
- Each lane has a registered output stage plus a one-entry skid buffer. A slow lane does not block the other lanes until that lane's skid buffer fills.

Parameters:
- WIDTH, 32, bits per lane.
- COUNT, 2, number of lanes and output streams; must be at least 1.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- s_valid  input  1  input beat valid.
- s_ready  output  1  input ready; registered.
- s_data  input  COUNT x WIDTH  packed lanes; lane n is s_data[n].
- m_valid  output  COUNT  per-lane output valid; registered.
- m_ready  input  COUNT  per-lane output ready.
- m_data  output  COUNT x WIDTH  per-lane output data; registered.

Behaviour:
- Reset (synchronous, active-high, checked at the clk edge):
  - s_ready=1, m_valid='0, all skid_valid=0.
  - m_data and skid data are don't-care.
  - Asserting reset mid-operation discards all held beats on the next edge, with no partial delivery afterwards.
- Definitions:
  - fire = s_valid & s_ready.
  - out_take[n] = m_valid[n] & m_ready[n].
  - out_free[n] = ~m_valid[n] | m_ready[n].
- Per-lane update on each edge (n = 0..COUNT-1):
  - fire & out_free[n]: m_data[n] <= s_data[n], m_valid[n] <= 1. The skid stays empty, because fire implies it is empty.
  - fire & ~out_free[n]: skid_data[n] <= s_data[n], skid_valid[n] <= 1. The output register holds.
  - ~fire & out_free[n] & skid_valid[n]: m_data[n] <= skid_data[n], m_valid[n] <= 1, skid_valid[n] <= 0.
  - ~fire & out_take[n] & ~skid_valid[n]: m_valid[n] <= 0.
  - Otherwise: hold.
- s_ready update:
  - s_ready <= ~|skid_valid_next, where skid_valid_next is the skid state after this edge.
  - Input is therefore accepted only when every lane can absorb one more beat.
- Latency: one cycle from an accepted input beat to m_valid on every lane whose output stage was free.
- Throughput: one beat per cycle while all m_ready are high.
- Ordering: each lane delivers beats in input order. The skid always drains before any newer beat reaches that lane, which is guaranteed because s_ready=0 while any skid is full.
- Atomic acceptance: every input beat is delivered exactly once on every lane. No lane drops or duplicates a beat.
- Stall rule: m_valid[n] & ~m_ready[n] at an edge implies m_valid[n] stays 1 and m_data[n] is stable on the next cycle. This is checked as a formal assertion under ifdef FORMAL, disabled during reset.
- Occupancy: at most 2 beats per lane (output register + skid). Lanes may differ by at most 2 beats in delivery progress.
- s_valid may be asserted with s_ready low. No beat is taken, and s_data is ignored in that cycle.
- When all lanes drain while s_valid is high, the next beat is accepted in the cycle after s_ready rises.
- COUNT=1 degenerates to a 2-entry pipeline register with a registered ready.

Test Plan:
- Reset then COUNT=2: apply s_data={B,A}={0x22,0x11}, s_valid=1, m_ready=2'b11 → next cycle m_valid=2'b11, m_data[0]=0x11, m_data[1]=0x22, s_ready=1.
- Full-rate streaming: send beats k=0..15 with lane n = k*16+n and all m_ready high → one beat per cycle, each lane sees a consecutive, gap-free sequence, and s_ready never drops.
- Single-lane stall: hold m_ready=2'b01 while sending beats 1,2,3.
  - Required: lane 0 delivers 1,2 back-to-back. Lane 1 holds 1 with m_data stable, its skid takes 2, and s_ready goes 0 after beat 2, so beat 3 is not accepted.
  - Then raise m_ready[1]: lane 1 delivers 1,2, s_ready returns to 1, and beat 3 reaches both lanes in order.
- Alternating random m_ready per lane with random s_valid, 10k cycles → a scoreboard per lane matches the input order exactly, with no loss or duplication, and the stall assertion is never violated.
- Reset mid-operation with both skids full → next cycle m_valid=0, s_ready=1, and no stale beat appears after reset is released.
- s_valid held high while s_ready=0 and s_data changing → s_data values presented during s_ready=0 never appear on any output.
